// File: rtl/clk_div_top_if.sv
// Parallel command bus between a host and the clock-divider register file.
interface clk_div_top_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            cmd_opt_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_data_i;
  logic [DATA_WIDTH-1:0] cmd_rdata_o;

  modport master (output cmd_opt_i, cmd_addr_i, cmd_data_i, input cmd_rdata_o);
  modport slave  (input cmd_opt_i, cmd_addr_i, cmd_data_i, output cmd_rdata_o);
endinterface

// File: rtl/clk_div_top.sv
// Programmable clock divider with register file reachable by cmd bus, UART (ratio load) and SPI.
// Define SPI_CFG_EN to compile in the SPI slave; otherwise spi_miso_o is tied low.
module clk_div_top #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic          clk_i,
  input  logic          rst_n,
  clk_div_top_if.slave  cmd,
  input  logic          uart_rx_i,
  input  logic          i2c_scl_i,
  inout  wire           i2c_sda_io,
  input  logic          spi_csn_i,
  input  logic          spi_clk_i,
  input  logic          spi_mosi_i,
  output logic          spi_miso_o,
  output logic          div_en_o,
  output logic          div_clk_o
);

  localparam int unsigned REG_W  = 16;
  localparam int unsigned BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RATIO  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(8'h08);

  typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;

  logic              r_ctrl_en;
  logic [REG_W-1:0]  r_ratio;
  logic [7:0]        r_last_rx;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic              r_div_en;
  logic              r_div_clk;
  logic [REG_W-1:0]  r_cnt;
  logic [REG_W-1:0]  r_neff;
  logic [REG_W-1:0]  w_neff_new;

  logic              w_cmd_wr;
  logic              w_cmd_rd;
  logic              w_spi_commit_c;
  logic [6:0]        w_spi_addr;
  logic [REG_W-1:0]  w_spi_data;

  uart_state_t       r_uart_state, w_uart_state_nxt;
  logic [BAUD_W-1:0] r_baud_cnt, w_baud_nxt;
  logic [2:0]        r_bit_idx, w_bit_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic              w_uart_done_c;
  logic              w_uart_good_c;
  logic              w_uart_ratio_wr_c;
  logic              r_rx_s1, r_rx_s2, r_rx_prev;

  // Register read mux shared by the cmd bus and the SPI shift-out load.
  function automatic logic [REG_W-1:0] f_reg_read(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  ctrl_en,
    input logic [REG_W-1:0]      ratio,
    input logic                  div_en,
    input logic                  div_clk,
    input logic [7:0]            last_rx
  );
    logic [REG_W-1:0] v;
    v = '0;
    case (addr)
      ADDR_CTRL:   v[0] = ctrl_en;
      ADDR_RATIO:  v = ratio;
      ADDR_STATUS: begin
        v[0]    = div_en;
        v[1]    = div_clk;
        v[15:8] = last_rx;
      end
      default:     v = '0;
    endcase
    return v;
  endfunction

  assign w_cmd_wr = (cmd.cmd_opt_i == 2'b10);
  assign w_cmd_rd = (cmd.cmd_opt_i == 2'b01);

  // Register file; cmd bus beats SPI beats UART when writes land in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_ctrl_en <= 1'b0;
      r_ratio   <= 16'd2;
      r_last_rx <= 8'h00;
      r_rdata   <= '0;
    end else begin
      if (w_cmd_wr) begin
        if (cmd.cmd_addr_i == ADDR_CTRL)       r_ctrl_en <= cmd.cmd_data_i[0];
        else if (cmd.cmd_addr_i == ADDR_RATIO) r_ratio   <= cmd.cmd_data_i[REG_W-1:0];
      end else if (w_spi_commit_c) begin
        if (w_spi_addr == 7'h00)      r_ctrl_en <= w_spi_data[0];
        else if (w_spi_addr == 7'h04) r_ratio   <= w_spi_data;
      end else if (w_uart_ratio_wr_c) begin
        r_ratio <= {8'h00, r_shift};
      end
      if (w_uart_good_c) r_last_rx <= r_shift;
      if (w_cmd_rd) begin
        r_rdata <= DATA_WIDTH'(f_reg_read(cmd.cmd_addr_i, r_ctrl_en, r_ratio,
                                          r_div_en, r_div_clk, r_last_rx));
      end
    end
  end

  assign cmd.cmd_rdata_o = r_rdata;

  assign w_neff_new = (r_ratio < 16'd2) ? 16'd2 : r_ratio;

  // Divider: the active ratio is only reloaded at wrap or while stopped, so periods never truncate.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_div_en  <= 1'b0;
      r_div_clk <= 1'b0;
      r_cnt     <= '0;
      r_neff    <= 16'd2;
    end else begin
      r_div_en <= r_ctrl_en;
      if (!r_ctrl_en) begin
        r_cnt     <= '0;
        r_div_clk <= 1'b0;
        r_neff    <= w_neff_new;
      end else begin
        r_div_clk <= (r_cnt < (r_neff >> 1));
        if (r_cnt == r_neff - 16'd1) begin
          r_cnt  <= '0;
          r_neff <= w_neff_new;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign div_en_o  = r_div_en;
  assign div_clk_o = r_div_clk;

  // UART state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_uart_state <= UART_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
    end else begin
      r_rx_s1      <= uart_rx_i;
      r_rx_s2      <= r_rx_s1;
      r_rx_prev    <= r_rx_s2;
      r_uart_state <= w_uart_state_nxt;
      r_baud_cnt   <= w_baud_nxt;
      r_bit_idx    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
    end
  end

  // UART next state: start confirmed at mid-bit, data sampled mid-bit LSB first.
  always_comb begin
    w_uart_state_nxt = r_uart_state;
    w_baud_nxt       = r_baud_cnt + BAUD_W'(1);
    w_bit_nxt        = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_uart_done_c    = 1'b0;
    case (r_uart_state)
      UART_IDLE: begin
        w_baud_nxt = '0;
        if (r_rx_prev && !r_rx_s2) w_uart_state_nxt = UART_START;
      end
      UART_START: begin
        if (r_baud_cnt == BAUD_HALF) begin
          w_baud_nxt       = '0;
          w_bit_nxt        = '0;
          w_uart_state_nxt = r_rx_s2 ? UART_IDLE : UART_DATA;
        end
      end
      UART_DATA: begin
        if (r_baud_cnt == BAUD_LAST) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {r_rx_s2, r_shift[7:1]};
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_uart_state_nxt = UART_STOP;
        end
      end
      UART_STOP: begin
        if (r_baud_cnt == BAUD_LAST) begin
          w_baud_nxt       = '0;
          w_uart_done_c    = 1'b1;
          w_uart_state_nxt = UART_IDLE;
        end
      end
      default: w_uart_state_nxt = UART_IDLE;
    endcase
  end

  assign w_uart_good_c     = w_uart_done_c & r_rx_s2;
  assign w_uart_ratio_wr_c = w_uart_good_c & (r_shift != 8'h00);

`ifdef SPI_CFG_EN
  logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic        r_csn_s1, r_csn_s2, r_csn_s3;
  logic        r_mosi_s1, r_mosi_s2;
  logic [4:0]  r_spi_cnt;
  logic [23:0] r_spi_in;
  logic [REG_W-1:0] r_spi_out;
  logic        r_spi_miso;
  logic        w_sclk_rise, w_sclk_fall, w_csn_rise;
  logic [23:0] w_spi_in_nxt;

  assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall  = ~r_sclk_s2 & r_sclk_s3;
  assign w_csn_rise   = r_csn_s2 & ~r_csn_s3;
  assign w_spi_in_nxt = {r_spi_in[22:0], r_mosi_s2};

  // SPI slave: bit count saturates so over-long frames are also rejected.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
      r_csn_s1  <= 1'b1; r_csn_s2  <= 1'b1; r_csn_s3  <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
      r_spi_cnt  <= '0;
      r_spi_in   <= '0;
      r_spi_out  <= '0;
      r_spi_miso <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_clk_i;  r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_csn_s1  <= spi_csn_i;  r_csn_s2  <= r_csn_s1;  r_csn_s3  <= r_csn_s2;
      r_mosi_s1 <= spi_mosi_i; r_mosi_s2 <= r_mosi_s1;
      if (r_csn_s2) begin
        r_spi_cnt  <= '0;
        r_spi_miso <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_spi_in <= w_spi_in_nxt;
          if (r_spi_cnt != 5'd31) r_spi_cnt <= r_spi_cnt + 5'd1;
          if (r_spi_cnt == 5'd7) begin
            r_spi_out <= f_reg_read(ADDR_WIDTH'(w_spi_in_nxt[6:0]), r_ctrl_en, r_ratio,
                                    r_div_en, r_div_clk, r_last_rx);
          end
        end
        if (w_sclk_fall && (r_spi_cnt >= 5'd8) && (r_spi_cnt <= 5'd23)) begin
          r_spi_miso <= r_spi_out[REG_W-1];
          r_spi_out  <= {r_spi_out[REG_W-2:0], 1'b0};
        end
      end
    end
  end

  assign w_spi_commit_c = w_csn_rise & (r_spi_cnt == 5'd24) & r_spi_in[23];
  assign w_spi_addr     = r_spi_in[22:16];
  assign w_spi_data     = r_spi_in[15:0];
  assign spi_miso_o     = r_spi_miso;
`else
  logic w_unused_spi;
  assign w_unused_spi   = ^{spi_csn_i, spi_clk_i, spi_mosi_i};
  assign w_spi_commit_c = 1'b0;
  assign w_spi_addr     = '0;
  assign w_spi_data     = '0;
  assign spi_miso_o     = 1'b0;
`endif

  // I2C pins are reserved: scl ignored, sda released.
  logic w_unused_misc;
  assign w_unused_misc = ^{i2c_scl_i, cmd.cmd_data_i[DATA_WIDTH-1:REG_W]};
  assign i2c_sda_io    = 1'bz;

endmodule

// File: tb/tb_clk_div_top.sv
// Directed self-checking bench for clk_div_top; SPI scenarios follow the SPI_CFG_EN build option.
module tb_clk_div_top;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned BAUD = 16;
  localparam int unsigned SPI_HALF = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, uart_rx, i2c_scl, spi_csn, spi_clk, spi_mosi;
  logic spi_miso, div_en, div_clk;
  wire  i2c_sda;
  int   errors = 0;
  int   checks = 0;

  clk_div_top_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cmd_if ();

  clk_div_top #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BAUD_DIV(BAUD)) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .uart_rx_i  (uart_rx),
    .i2c_scl_i  (i2c_scl),
    .i2c_sda_io (i2c_sda),
    .spi_csn_i  (spi_csn),
    .spi_clk_i  (spi_clk),
    .spi_mosi_i (spi_mosi),
    .spi_miso_o (spi_miso),
    .div_en_o   (div_en),
    .div_clk_o  (div_clk)
  );

  // All tasks start and end on a negedge.
  task automatic cmd_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cmd_if.cmd_opt_i  = 2'b10;
    cmd_if.cmd_addr_i = addr;
    cmd_if.cmd_data_i = data;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_opt_i  = 2'b00;
  endtask

  task automatic cmd_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    cmd_if.cmd_opt_i  = 2'b01;
    cmd_if.cmd_addr_i = addr;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_opt_i  = 2'b00;
    data = cmd_if.cmd_rdata_o;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  // Sends the top nbits of frame; optionally lands a cmd write on the SPI commit cycle.
  task automatic spi_frame(input int nbits, input logic [23:0] frame,
                           output logic [15:0] miso_word, input bit collide);
    miso_word = '0;
    spi_csn = 1'b0;
    repeat (SPI_HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = frame[23-i];
      spi_clk  = 1'b0;
      repeat (SPI_HALF) @(negedge clk);
      if (i >= 8 && i < 24) miso_word[23-i] = spi_miso;
      spi_clk = 1'b1;
      repeat (SPI_HALF) @(negedge clk);
    end
    spi_clk = 1'b0;
    repeat (SPI_HALF) @(negedge clk);
    spi_csn = 1'b1;
    if (collide) begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_opt_i  = 2'b10;
      cmd_if.cmd_addr_i = 8'h04;
      cmd_if.cmd_data_i = 32'd3;
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_opt_i  = 2'b00;
    end
    repeat (SPI_HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] exps  [4];
    addrs = '{8'h04, 8'h00, 8'h08, 8'h0C};
    exps  = '{32'd2, 32'd0, 32'd0, 32'd0};
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (div_en !== 1'b0) begin errors++; $display("FAIL reset_div_en: got %b expected 0", div_en); end
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL reset_div_clk: got %b expected 0", div_clk); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    checks++; if (cmd_if.cmd_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", cmd_if.cmd_rdata_o); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cmd_read(addrs[i], rd);
      checks++;
      if (rd !== exps[i]) begin errors++; $display("FAIL reset_read_%h: got %h expected %h", addrs[i], rd, exps[i]); end
    end
  endtask

  task automatic test_divider();
    logic [DW-1:0] rd;
    logic [7:0] pat;
    pat = 8'b1100_1100;
    cmd_write(8'h04, 32'hFFFF_0004);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd4) begin errors++; $display("FAIL ratio_upper_zero: got %h expected 4", rd); end
    cmd_write(8'h00, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        checks++; if (div_en !== 1'b1) begin errors++; $display("FAIL div_en_rise: got %b expected 1", div_en); end
      end
      checks++;
      if (div_clk !== pat[7-i]) begin errors++; $display("FAIL div4_cycle%0d: got %b expected %b", i, div_clk, pat[7-i]); end
    end
    cmd_read(8'h08, rd);
    checks++; if ((rd & 32'hFFFF_FF01) !== 32'd1) begin errors++; $display("FAIL status_en: got %h expected bit0=1 rest 0", rd); end
    cmd_read(8'h00, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL ctrl_read: got %h expected 1", rd); end
  endtask

  task automatic test_ratio_values();
    logic [15:0] ratios [4];
    logic [9:0]  pats   [4];
    logic [9:0]  p;
    ratios = '{16'd5, 16'd0, 16'd1, 16'd3};
    pats   = '{10'b1100011000, 10'b1010101010, 10'b1010101010, 10'b1001001001};
    for (int t = 0; t < 4; t++) begin
      p = pats[t];
      cmd_write(8'h00, 32'd0);
      cmd_write(8'h04, 32'(ratios[t]));
      cmd_write(8'h00, 32'd1);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (div_clk !== p[9-i]) begin
          errors++;
          $display("FAIL ratio%0d_cycle%0d: got %b expected %b", ratios[t], i, div_clk, p[9-i]);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    logic [9:0] pat;
    pat = 10'b1100111000;
    cmd_write(8'h00, 32'd0);
    cmd_write(8'h04, 32'd4);
    cmd_write(8'h00, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        cmd_if.cmd_opt_i  = 2'b10;
        cmd_if.cmd_addr_i = 8'h04;
        cmd_if.cmd_data_i = 32'd6;
      end else begin
        cmd_if.cmd_opt_i = 2'b00;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (div_clk !== pat[9-i]) begin errors++; $display("FAIL change4to6_cycle%0d: got %b expected %b", i, div_clk, pat[9-i]); end
    end
    cmd_if.cmd_opt_i = 2'b00;
    cmd_write(8'h00, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checks++; if (div_en !== 1'b0) begin errors++; $display("FAIL disable_en: got %b expected 0", div_en); end
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL disable_clk: got %b expected 0", div_clk); end
  endtask

  task automatic test_uart();
    logic [DW-1:0] rd;
    uart_send(8'h0A, 1'b1);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL uart_ratio: got %h expected 0000000a", rd); end
    cmd_read(8'h08, rd);
    checks++; if (rd[15:8] !== 8'h0A) begin errors++; $display("FAIL uart_last_rx: got %h expected 0a", rd[15:8]); end
    uart_send(8'h33, 1'b0);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL uart_bad_stop_ratio: got %h expected 0000000a", rd); end
    cmd_read(8'h08, rd);
    checks++; if (rd[15:8] !== 8'h0A) begin errors++; $display("FAIL uart_bad_stop_last: got %h expected 0a", rd[15:8]); end
    uart_send(8'h00, 1'b1);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL uart_zero_ratio: got %h expected 0000000a", rd); end
    cmd_read(8'h08, rd);
    checks++; if (rd[15:8] !== 8'h00) begin errors++; $display("FAIL uart_zero_last: got %h expected 00", rd[15:8]); end
  endtask

`ifdef SPI_CFG_EN
  task automatic test_spi();
    logic [DW-1:0] rd;
    logic [15:0]   mw;
    spi_frame(24, {1'b1, 7'h04, 16'd8}, mw, 1'b0);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL spi_write: got %h expected 8", rd); end
    spi_frame(24, {1'b0, 7'h04, 16'hA5A5}, mw, 1'b0);
    checks++; if (mw !== 16'h0008) begin errors++; $display("FAIL spi_readback: got %h expected 0008", mw); end
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL spi_read_no_write: got %h expected 8", rd); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL spi_miso_idle: got %b expected 0", spi_miso); end
    spi_frame(20, {1'b1, 7'h04, 16'd9}, mw, 1'b0);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL spi_short_frame: got %h expected 8", rd); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] rd;
    logic [15:0]   mw;
    spi_frame(24, {1'b1, 7'h04, 16'd7}, mw, 1'b1);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd3) begin errors++; $display("FAIL cmd_over_spi: got %h expected 3", rd); end
  endtask
`else
  task automatic test_spi_absent();
    logic [DW-1:0] rd;
    logic [15:0]   mw;
    spi_frame(24, {1'b1, 7'h04, 16'd7}, mw, 1'b0);
    checks++; if (mw !== 16'h0000) begin errors++; $display("FAIL spi_absent_miso: got %h expected 0000", mw); end
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd10) begin errors++; $display("FAIL spi_absent_write: got %h expected 0000000a", rd); end
  endtask
`endif

  task automatic test_uart_reset();
    logic [DW-1:0] rd;
    logic [7:0] b;
    b = 8'h0F;
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    uart_rx = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (BAUD * 12) @(negedge clk);
    cmd_read(8'h04, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL uart_reset_ratio: got %h expected 2", rd); end
    cmd_read(8'h08, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL uart_reset_status: got %h expected 0", rd); end
  endtask

  initial begin
    rst_n    = 1'b0;
    uart_rx  = 1'b1;
    i2c_scl  = 1'b1;
    spi_csn  = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    cmd_if.cmd_opt_i  = 2'b00;
    cmd_if.cmd_addr_i = '0;
    cmd_if.cmd_data_i = '0;
    @(negedge clk);
    test_reset();
    test_divider();
    test_ratio_values();
    test_mid_change();
    test_uart();
`ifdef SPI_CFG_EN
    test_spi();
    test_priority();
`else
    test_spi_absent();
`endif
    test_uart_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
